// File: rtl/run_seq_pkg.sv
// run_seq_pkg: shared types and constants for the run sequencer.
//   run_state_t   - sequencer state (IDLE, HOLD, RUN, PASS, FAIL)
//   FAIL_*        - fail_code encodings reported to the harness owner
//   DEF_*_W       - default counter and config field widths
package run_seq_pkg;

    localparam int unsigned DEF_CYCLE_W = 64;
    localparam int unsigned DEF_HOLD_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HOLD,
        ST_RUN,
        ST_PASS,
        ST_FAIL
    } run_state_t;

    localparam logic [1:0] FAIL_NONE    = 2'd0;
    localparam logic [1:0] FAIL_HARNESS = 2'd1;
    localparam logic [1:0] FAIL_TIMEOUT = 2'd2;

endpackage

// File: rtl/run_seq_cycle_counter.sv
// run_seq_cycle_counter: saturating run-cycle counter with timeout compare.
//   clock, reset   - system clock, synchronous active-low reset
//   clear          - zero the count (new run launched)
//   enable         - count this cycle (one RUN cycle completed)
//   limit          - timeout limit; 0 disables the timeout
//   count          - completed cycles, saturating at all-ones
//   timeout        - the cycle currently being counted exceeds limit
module run_seq_cycle_counter
    import run_seq_pkg::*;
#(
    parameter int unsigned CYCLE_W = DEF_CYCLE_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clear,
    input  logic               enable,
    input  logic [CYCLE_W-1:0] limit,
    output logic [CYCLE_W-1:0] count,
    output logic               timeout
);

    localparam logic [CYCLE_W-1:0] COUNT_ONE = {{(CYCLE_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clock) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + COUNT_ONE;
        end
    end

    // During RUN cycle k the register still holds k-1, so k > limit is
    // evaluated as count >= limit; this never overflows and stays true
    // once the count has saturated.
    assign timeout = (limit != '0) && (count >= limit);

endmodule

// File: rtl/run_sequencer.sv
// run_sequencer: sequences a harness run - reset hold, run, pass/fail/timeout.
//   clock, reset        - system clock, synchronous active-low reset
//   start               - launch pulse, accepted in IDLE/PASS/FAIL only
//   cfg_max_cycles      - timeout limit (0 = none), latched on start
//   cfg_reset_hold      - harness reset length (0 treated as 1), latched on start
//   cfg_dump_start      - run cycle where capture begins (window mode only)
//   harness_success/failure - harness status flags, sampled in RUN
//   dut_reset           - active-high reset to the harness
//   dump_on             - waveform/trace capture enable
//   done, passed, fail_code - run result
//   cycle_count         - completed RUN cycles, saturating
// Build option: RUN_SEQ_DUMP_WINDOW_EN enables the cfg_dump_start capture
// window; without it dump_on simply covers HOLD and RUN.
module run_sequencer
    import run_seq_pkg::*;
#(
    parameter int unsigned CYCLE_W = DEF_CYCLE_W,
    parameter int unsigned HOLD_W  = DEF_HOLD_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [CYCLE_W-1:0] cfg_max_cycles,
    input  logic [HOLD_W-1:0]  cfg_reset_hold,
    input  logic [CYCLE_W-1:0] cfg_dump_start,
    input  logic               harness_success,
    input  logic               harness_failure,
    output logic               dut_reset,
    output logic               dump_on,
    output logic               done,
    output logic               passed,
    output logic [1:0]         fail_code,
    output logic [CYCLE_W-1:0] cycle_count
);

    localparam logic [HOLD_W-1:0] HOLD_ONE = {{(HOLD_W-1){1'b0}}, 1'b1};

    run_state_t         state_q, state_d;
    logic [HOLD_W-1:0]  hold_len_q;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [CYCLE_W-1:0] max_cycles_q;
    logic               start_ok;
    logic               timeout;
    logic               dut_reset_d, dump_on_d, done_d, passed_d;
    logic [1:0]         fail_code_d;

    assign start_ok = start &&
                      ((state_q == ST_IDLE) || (state_q == ST_PASS) || (state_q == ST_FAIL));

    run_seq_cycle_counter #(
        .CYCLE_W (CYCLE_W)
    ) u_cycle_counter (
        .clock   (clock),
        .reset   (reset),
        .clear   (start_ok),
        .enable  (state_q == ST_RUN),
        .limit   (max_cycles_q),
        .count   (cycle_count),
        .timeout (timeout)
    );

    // Configuration latched at launch; later cfg changes wait for the next start.
    always_ff @(posedge clock) begin
        if (!reset) begin
            hold_len_q   <= HOLD_ONE;
            max_cycles_q <= '0;
        end else if (start_ok) begin
            hold_len_q   <= (cfg_reset_hold == '0) ? HOLD_ONE : cfg_reset_hold;
            max_cycles_q <= cfg_max_cycles;
        end
    end

`ifdef RUN_SEQ_DUMP_WINDOW_EN
    logic [CYCLE_W-1:0] dump_start_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            dump_start_q <= '0;
        end else if (start_ok) begin
            dump_start_q <= cfg_dump_start;
        end
    end
`else
    logic unused_dump_start;
    assign unused_dump_start = ^cfg_dump_start;
`endif

    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        done_d      = done;
        passed_d    = passed;
        fail_code_d = fail_code;

        unique case (state_q)
            ST_IDLE, ST_PASS, ST_FAIL: begin
                if (start_ok) begin
                    state_d     = ST_HOLD;
                    hold_cnt_d  = HOLD_ONE;
                    done_d      = 1'b0;
                    passed_d    = 1'b0;
                    fail_code_d = FAIL_NONE;
                end
            end
            ST_HOLD: begin
                if (hold_cnt_q >= hold_len_q) begin
                    state_d = ST_RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_ONE;
                end
            end
            ST_RUN: begin
                if (harness_failure) begin
                    state_d     = ST_FAIL;
                    done_d      = 1'b1;
                    fail_code_d = FAIL_HARNESS;
                end else if (timeout) begin
                    state_d     = ST_FAIL;
                    done_d      = 1'b1;
                    fail_code_d = FAIL_TIMEOUT;
                end else if (harness_success) begin
                    state_d  = ST_PASS;
                    done_d   = 1'b1;
                    passed_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        dut_reset_d = (state_d != ST_RUN);

`ifdef RUN_SEQ_DUMP_WINDOW_EN
        // HOLD entry uses the value being latched this edge.
        unique case (state_d)
            ST_HOLD: dump_on_d = start_ok ? (cfg_dump_start == '0) : (dump_start_q == '0);
            ST_RUN:  dump_on_d = (cycle_count >= dump_start_q);
            default: dump_on_d = 1'b0;
        endcase
`else
        dump_on_d = (state_d == ST_HOLD) || (state_d == ST_RUN);
`endif
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= '0;
            dut_reset  <= 1'b1;
            dump_on    <= 1'b0;
            done       <= 1'b0;
            passed     <= 1'b0;
            fail_code  <= FAIL_NONE;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            dut_reset  <= dut_reset_d;
            dump_on    <= dump_on_d;
            done       <= done_d;
            passed     <= passed_d;
            fail_code  <= fail_code_d;
        end
    end

endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer: randomized self-checking bench for run_sequencer.
// Each run's outcome is predicted from the config and the flag schedule,
// then every output is checked on every cycle of the run.
module tb_run_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [63:0] cfg_max_cycles = '0;
    logic [15:0] cfg_reset_hold = '0;
    logic [63:0] cfg_dump_start = '0;
    logic        harness_success = 1'b0;
    logic        harness_failure = 1'b0;
    logic        dut_reset, dump_on, done, passed;
    logic [1:0]  fail_code;
    logic [63:0] cycle_count;

    int n_compared = 0;
    int n_mismatched = 0;

    run_sequencer #(
        .CYCLE_W (64),
        .HOLD_W  (16)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .cfg_max_cycles  (cfg_max_cycles),
        .cfg_reset_hold  (cfg_reset_hold),
        .cfg_dump_start  (cfg_dump_start),
        .harness_success (harness_success),
        .harness_failure (harness_failure),
        .dut_reset       (dut_reset),
        .dump_on         (dump_on),
        .done            (done),
        .passed          (passed),
        .fail_code       (fail_code),
        .cycle_count     (cycle_count)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Outcome of a run: the first RUN cycle where failure, timeout or
    // success applies, in that priority. Flags are single-cycle at the
    // given RUN cycle (0 = never raised).
    task automatic predict(input int maxc, input int succ_k, input int fail_k,
                           output int kend, output int code);
        kend = 0;
        code = 0;
        for (int k = 1; k <= 5000; k++) begin
            if (k == fail_k) begin
                kend = k; code = 1; break;
            end else if (maxc != 0 && k > maxc) begin
                kend = k; code = 2; break;
            end else if (k == succ_k) begin
                kend = k; code = 0; break;
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".dut_reset"},   64'(dut_reset),   64'd1);
        check({tag, ".dump_on"},     64'(dump_on),     64'd0);
        check({tag, ".done"},        64'(done),        64'd0);
        check({tag, ".passed"},      64'(passed),      64'd0);
        check({tag, ".fail_code"},   64'(fail_code),   64'd0);
        check({tag, ".cycle_count"}, cycle_count,      64'd0);
    endtask

    // Launch one run and check every output on each cycle after start.
    // start_j: cycle (after launch) where a stray start is pulsed, 0 = none.
    task automatic run_one(input int hold, input int maxc, input int dstart,
                           input int succ_k, input int fail_k, input int start_j);
        int h, kend, code, k, e_cnt;
        bit in_run, fin, e_dump;
        h = (hold == 0) ? 1 : hold;
        predict(maxc, succ_k, fail_k, kend, code);
        cfg_reset_hold  = 16'(hold);
        cfg_max_cycles  = 64'(maxc);
        cfg_dump_start  = 64'(dstart);
        harness_success = 1'($urandom_range(0, 1));
        harness_failure = 1'($urandom_range(0, 1));
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int j = 1; j <= h + kend + 3; j++) begin
            k      = j - h;
            in_run = (j > h) && (j <= h + kend);
            fin    = (j > h + kend);
            if (in_run) begin
                harness_success = (k == succ_k);
                harness_failure = (k == fail_k);
            end else begin
                harness_success = 1'($urandom_range(0, 1));
                harness_failure = 1'($urandom_range(0, 1));
            end
            start = (j == start_j) && (j <= h + kend);
            // Config churn after launch must have no effect.
            cfg_reset_hold = 16'($urandom_range(0, 9));
            cfg_max_cycles = 64'($urandom_range(0, 3));
            cfg_dump_start = 64'($urandom_range(0, 3));

            e_cnt = (j <= h) ? 0 : ((j - h - 1 < kend) ? j - h - 1 : kend);
`ifdef RUN_SEQ_DUMP_WINDOW_EN
            if (j <= h)      e_dump = (dstart == 0);
            else if (in_run) e_dump = (((k >= 2) ? k - 2 : 0) >= dstart);
            else             e_dump = 1'b0;
`else
            e_dump = (j <= h + kend);
`endif
            check("dut_reset",   64'(dut_reset), 64'(!in_run));
            check("cycle_count", cycle_count,    64'(e_cnt));
            check("done",        64'(done),      64'(fin));
            check("passed",      64'(passed),    64'(fin && code == 0));
            check("fail_code",   64'(fail_code), fin ? 64'(code) : 64'd0);
            check("dump_on",     64'(dump_on),   64'(e_dump));
            @(negedge clock);
        end
        start = 1'b0;
    endtask

    initial begin
        int hold, maxc, succ, fail, dstart, sj;
        repeat (3) @(negedge clock);
        check_reset_values("por");
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check_reset_values("idle");

        // hold 5 + pass at RUN cycle 40
        run_one(5, 100, 20, 40, 0, 0);
        // hold 0 behaves as 1
        run_one(0, 0, 0, 3, 0, 0);
        // timeout at cycle 11
        run_one(2, 10, 0, 0, 0, 0);
        // success and failure together: failure wins
        run_one(1, 0, 5, 7, 7, 0);
        // failure in the timeout cycle: failure wins
        run_one(3, 10, 1, 0, 11, 0);
        // capture window starting at 20
        run_one(4, 0, 20, 30, 0, 0);
        // stray start during RUN and during HOLD are ignored
        run_one(2, 0, 3, 10, 0, 7);
        run_one(4, 0, 0, 6, 0, 2);

        // reset asserted in RUN cycle 3
        cfg_reset_hold = 16'd2;
        cfg_max_cycles = 64'd0;
        harness_success = 1'b0;
        harness_failure = 1'b0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        check("midrst.pre_count", cycle_count, 64'd2);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        check_reset_values("midrst");
        harness_success = 1'b1;
        repeat (3) @(negedge clock);
        check_reset_values("midrst.idle");

        for (int r = 0; r < 40; r++) begin
            hold   = $urandom_range(0, 6);
            maxc   = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 30);
            succ   = $urandom_range(0, 40);
            fail   = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 40) : 0;
            dstart = $urandom_range(0, 25);
            sj     = ($urandom_range(0, 1) == 1) ? $urandom_range(1, ((hold == 0) ? 1 : hold) + 1) : 0;
            if (maxc == 0 && succ == 0 && fail == 0) succ = 5;
            run_one(hold, maxc, dstart, succ, fail, sj);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
